// File: rtl/move_sequencer_if.sv
// Move handshake, shared board read/write port, victory-checker link, display
// port and game status of the move sequencer, bundled into one interface.
interface move_sequencer_if;
   logic       new_game;
   logic       move_valid;
   logic [2:0] move_col;
   logic       move_ready;
   logic       move_reject;

   logic [2:0] rd_row;
   logic [2:0] rd_col;
   logic [1:0] rd_data;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [2:0] wr_col;
   logic [1:0] wr_data;

   logic       chk_start;
   logic [2:0] chk_row;
   logic [2:0] chk_col;
   logic [2:0] chk_read_row;
   logic [2:0] chk_read_col;
   logic       chk_done;
   logic [1:0] chk_winner;

   logic [2:0] disp_row;
   logic [2:0] disp_col;
   logic [1:0] disp_data;
   logic       disp_valid;

   logic [1:0] current_player;
   logic       game_over;
   logic [1:0] winner;

   // Environment side: player input, board store, victory checker, display.
   modport master (
      output new_game, move_valid, move_col, rd_data,
             chk_read_row, chk_read_col, chk_done, chk_winner,
             disp_row, disp_col,
      input  move_ready, move_reject, rd_row, rd_col,
             wr_en, wr_row, wr_col, wr_data,
             chk_start, chk_row, chk_col, disp_data, disp_valid,
             current_player, game_over, winner
   );

   modport slave (
      input  new_game, move_valid, move_col, rd_data,
             chk_read_row, chk_read_col, chk_done, chk_winner,
             disp_row, disp_col,
      output move_ready, move_reject, rd_row, rd_col,
             wr_en, wr_row, wr_col, wr_data,
             chk_start, chk_row, chk_col, disp_data, disp_valid,
             current_player, game_over, winner
   );
endinterface

// File: rtl/move_sequencer.sv
// Game sequencer: clears the board, drops pieces into columns, hands each new
// piece to the victory checker and arbitrates the single board read port.
module move_sequencer #(
   parameter int NUM_ROWS = 8,
   parameter int NUM_COLS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   move_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_SCAN,
      S_WRITE,
      S_CHECK_START,
      S_CHECK_WAIT,
      S_OVER
   } state_t;

   localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);
   localparam logic [2:0] LAST_COL  = 3'(NUM_COLS - 1);
   localparam logic [6:0] NUM_CELLS = 7'(NUM_ROWS * NUM_COLS);
   localparam logic [1:0] PLAYER_1  = 2'b01;
   localparam logic [1:0] PLAYER_2  = 2'b10;
   localparam logic [1:0] DRAW      = 2'b11;

   state_t     state_q, state_d;
   logic [2:0] clr_row_q, clr_row_d;
   logic [2:0] clr_col_q, clr_col_d;
   logic [2:0] scan_row_q, scan_row_d;
   logic [2:0] target_row_q, target_row_d;
   logic [2:0] col_q, col_d;
   logic [6:0] piece_count_q, piece_count_d;
   logic [1:0] player_q, player_d;
   logic [1:0] winner_q, winner_d;
   logic       game_over_q, game_over_d;

   logic       restart;
   logic       col_out_of_range;

   assign restart          = bus.new_game && (state_q != S_CLEAR);
   assign col_out_of_range = {1'b0, bus.move_col} >= 4'(NUM_COLS);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_CLEAR;
         clr_row_q     <= '0;
         clr_col_q     <= '0;
         scan_row_q    <= '0;
         target_row_q  <= '0;
         col_q         <= '0;
         piece_count_q <= '0;
         player_q      <= PLAYER_1;
         winner_q      <= '0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_row_q     <= clr_row_d;
         clr_col_q     <= clr_col_d;
         scan_row_q    <= scan_row_d;
         target_row_q  <= target_row_d;
         col_q         <= col_d;
         piece_count_q <= piece_count_d;
         player_q      <= player_d;
         winner_q      <= winner_d;
         game_over_q   <= game_over_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      clr_row_d     = clr_row_q;
      clr_col_d     = clr_col_q;
      scan_row_d    = scan_row_q;
      target_row_d  = target_row_q;
      col_d         = col_q;
      piece_count_d = piece_count_q;
      player_d      = player_q;
      winner_d      = winner_q;
      game_over_d   = game_over_q;

      bus.move_ready  = 1'b0;
      bus.move_reject = 1'b0;
      bus.wr_en       = 1'b0;
      bus.wr_row      = '0;
      bus.wr_col      = '0;
      bus.wr_data     = '0;
      bus.chk_start   = 1'b0;
      bus.rd_row      = bus.disp_row;
      bus.rd_col      = bus.disp_col;
      bus.disp_valid  = 1'b0;

      unique case (state_q)
         S_CLEAR: begin
            // Strobe stays quiet while reset is held, even though the state is CLEAR.
            bus.wr_en  = rst_n;
            bus.wr_row = clr_row_q;
            bus.wr_col = clr_col_q;
            if (clr_col_q == LAST_COL) begin
               clr_col_d = '0;
               if (clr_row_q == LAST_ROW) begin
                  clr_row_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  clr_row_d = clr_row_q + 3'd1;
               end
            end else begin
               clr_col_d = clr_col_q + 3'd1;
            end
         end

         S_IDLE: begin
            bus.move_ready = 1'b1;
            bus.disp_valid = 1'b1;
            if (bus.move_valid && !restart) begin
               if (col_out_of_range) begin
                  bus.move_reject = 1'b1;
               end else begin
                  col_d      = bus.move_col;
                  scan_row_d = '0;
                  state_d    = S_SCAN;
               end
            end
         end

         S_SCAN: begin
            bus.rd_row = scan_row_q;
            bus.rd_col = col_q;
            if (bus.rd_data == 2'b00) begin
               target_row_d = scan_row_q;
               state_d      = S_WRITE;
            end else if (scan_row_q == LAST_ROW) begin
               bus.move_reject = !restart;
               state_d         = S_IDLE;
            end else begin
               scan_row_d = scan_row_q + 3'd1;
            end
         end

         S_WRITE: begin
            bus.wr_en     = 1'b1;
            bus.wr_row    = target_row_q;
            bus.wr_col    = col_q;
            bus.wr_data   = player_q;
            piece_count_d = piece_count_q + 7'd1;
            state_d       = S_CHECK_START;
         end

         S_CHECK_START: begin
            bus.chk_start = 1'b1;
            bus.rd_row    = bus.chk_read_row;
            bus.rd_col    = bus.chk_read_col;
            state_d       = S_CHECK_WAIT;
         end

         S_CHECK_WAIT: begin
            bus.rd_row = bus.chk_read_row;
            bus.rd_col = bus.chk_read_col;
            if (bus.chk_done) begin
               if (bus.chk_winner != 2'b00) begin
                  winner_d    = bus.chk_winner;
                  game_over_d = 1'b1;
                  state_d     = S_OVER;
               end else if (piece_count_q == NUM_CELLS) begin
                  winner_d    = DRAW;
                  game_over_d = 1'b1;
                  state_d     = S_OVER;
               end else begin
                  player_d = (player_q == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                  state_d  = S_IDLE;
               end
            end
         end

         S_OVER: begin
            bus.disp_valid = 1'b1;
         end

         default: state_d = S_CLEAR;
      endcase

      // A new game overrides whatever the current state decided.
      if (restart) begin
         state_d       = S_CLEAR;
         clr_row_d     = '0;
         clr_col_d     = '0;
         piece_count_d = '0;
         player_d      = PLAYER_1;
         winner_d      = '0;
         game_over_d   = 1'b0;
      end
   end

   assign bus.chk_row        = target_row_q;
   assign bus.chk_col        = col_q;
   assign bus.disp_data      = bus.rd_data;
   assign bus.current_player = player_q;
   assign bus.game_over      = game_over_q;
   assign bus.winner         = winner_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: random drops checked against a column-height
// model; expected writes, rejects and checker starts go through a scoreboard.
`timescale 1ns/1ps
module tb_move_sequencer;
   localparam int ROWS  = 8;
   localparam int COLS  = 7;
   localparam int CELLS = ROWS * COLS;

   typedef enum logic [1:0] {EV_WRITE, EV_REJECT, EV_CHK} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [2:0]  row;
      logic [2:0]  col;
      logic [1:0]  data;
      logic [31:0] cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   ev_t         exp_q[$];
   logic [1:0]  board_mem [8][8];

   // Reference model: column heights, cell owners and game status.
   int          heights [COLS];
   logic [1:0]  cells [ROWS][COLS];
   logic [1:0]  m_player;
   logic [1:0]  m_winner;
   logic        m_over;
   int          m_pieces;

   move_sequencer_if bus();

   move_sequencer #(.NUM_ROWS(ROWS), .NUM_COLS(COLS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Board store: stale contents while reset is held, so the sweep must clear them.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) board_mem[r][c] <= 2'b11;
      end else if (bus.wr_en) begin
         board_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
   end
   assign bus.rd_data = board_mem[bus.rd_row][bus.rd_col];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void expect_ev(ev_kind_t k, int r, int c, logic [1:0] d, int unsigned t);
      exp_q.push_back(ev_t'{k, 3'(r), 3'(c), d, t});
   endfunction

   task automatic observe(input ev_t got, input string name);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: got unexpected event %0h, nothing expected", name, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, e);
         end
      end
   endtask

   // Monitor: every strobe the DUT presents must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_en)
            observe(ev_t'{EV_WRITE, bus.wr_row, bus.wr_col, bus.wr_data, cyc}, "write");
         if (bus.move_reject)
            observe(ev_t'{EV_REJECT, 3'd0, 3'd0, 2'd0, cyc}, "reject");
         if (bus.chk_start)
            observe(ev_t'{EV_CHK, bus.chk_row, bus.chk_col, 2'd0, cyc}, "chk_start");
      end else begin
         check("reset_quiet", {bus.wr_en, bus.move_reject, bus.chk_start, bus.move_ready}, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The sweep writes cell i at cycle start+i; the model restarts a fresh game.
   task automatic expect_clear(input int unsigned start);
      for (int i = 0; i < CELLS; i++) expect_ev(EV_WRITE, i / COLS, i % COLS, 2'b00, start + i);
      for (int c = 0; c < COLS; c++) heights[c] = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) cells[r][c] = 2'b00;
      m_player = 2'b01;
      m_winner = 2'b00;
      m_over   = 1'b0;
      m_pieces = 0;
   endtask

   task automatic check_status(input string name);
      check({name, "_ready"},  bus.move_ready, !m_over);
      check({name, "_player"}, bus.current_player, m_player);
      check({name, "_over"},   bus.game_over, m_over);
      check({name, "_winner"}, bus.winner, m_winner);
   endtask

   task automatic wait_clear_done(input int unsigned start);
      while (cyc < start + CELLS) tick();
      check("clear_drained", exp_q.size(), 0);
      check_status("after_clear");
   endtask

   task automatic check_display();
      int r;
      int c;
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      bus.disp_row = 3'(r);
      bus.disp_col = 3'(c);
      #1;
      check("disp_valid", bus.disp_valid, 1);
      check("disp_addr", {bus.rd_row, bus.rd_col}, {3'(r), 3'(c)});
      check("disp_data", bus.disp_data, cells[r][c]);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.move_ready && n < 300) begin
         tick();
         n++;
      end
      check("ready_timeout", bus.move_ready, 1);
   endtask

   task automatic new_game_now();
      int unsigned g;
      g = cyc;
      expect_clear(g + 1);
      bus.new_game = 1'b1;
      tick();
      bus.new_game = 1'b0;
      wait_clear_done(g + 1);
   endtask

   function automatic int pick_open_col();
      int c;
      c = $urandom_range(0, COLS - 1);
      for (int i = 0; i < COLS && heights[c] >= ROWS; i++) c = (c + 1) % COLS;
      return c;
   endfunction

   // One drop: expectations are queued before the request is driven.
   task automatic do_move(input int col, input logic [1:0] res, input bit abort);
      int unsigned c;
      int unsigned g;
      int          h;
      int          rr;
      int          rc;
      wait_ready();
      c = cyc;
      h = (col < COLS) ? heights[col] : 0;
      if (col >= COLS) expect_ev(EV_REJECT, 0, 0, 2'b00, c);
      else if (h == ROWS) expect_ev(EV_REJECT, 0, 0, 2'b00, c + ROWS);
      else begin
         expect_ev(EV_WRITE, h, col, m_player, c + 2 + h);
         expect_ev(EV_CHK, h, col, 2'b00, c + 3 + h);
      end
      bus.move_valid = 1'b1;
      bus.move_col   = 3'(col);
      tick();
      bus.move_valid = 1'b0;
      if (col >= COLS || h == ROWS) begin
         if (col < COLS) while (cyc < c + ROWS + 1) tick();
         check_status("after_reject");
         return;
      end
      cells[h][col] = m_player;
      heights[col]++;
      m_pieces++;
      g = c + 4 + h + $urandom_range(0, 3);
      while (cyc < g) tick();
      if (abort) begin
         g = cyc;
         expect_clear(g + 1);
         bus.new_game = 1'b1;
         tick();
         bus.new_game = 1'b0;
         repeat (3) tick();
         bus.chk_done   = 1'b1;
         bus.chk_winner = 2'b10;
         tick();
         bus.chk_done   = 1'b0;
         bus.chk_winner = 2'b00;
         wait_clear_done(g + 1);
         return;
      end
      rr = $urandom_range(0, 7);
      rc = $urandom_range(0, 7);
      bus.chk_read_row = 3'(rr);
      bus.chk_read_col = 3'(rc);
      bus.chk_done     = 1'b1;
      bus.chk_winner   = res;
      @(negedge clk);
      check("chk_read_addr", {bus.rd_row, bus.rd_col}, {3'(rr), 3'(rc)});
      check("chk_disp_valid", bus.disp_valid, 0);
      tick();
      bus.chk_done   = 1'b0;
      bus.chk_winner = 2'b00;
      if (res != 2'b00) begin
         m_winner = res;
         m_over   = 1'b1;
      end else if (m_pieces == CELLS) begin
         m_winner = 2'b11;
         m_over   = 1'b1;
      end else begin
         m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
      end
      check_status("after_move");
      check_display();
   endtask

   initial begin
      int guard;
      rst_n            = 1'b0;
      bus.new_game     = 1'b0;
      bus.move_valid   = 1'b0;
      bus.move_col     = '0;
      bus.chk_done     = 1'b0;
      bus.chk_winner   = '0;
      bus.chk_read_row = '0;
      bus.chk_read_col = '0;
      bus.disp_row     = '0;
      bus.disp_col     = '0;
      repeat (3) tick();
      check("rst_player", bus.current_player, 2'b01);
      check("rst_over", bus.game_over, 0);
      check("rst_winner", bus.winner, 2'b00);

      expect_clear(cyc);
      rst_n = 1'b1;
      wait_clear_done(cyc);
      check_display();

      do_move(3, 2'b00, 1'b0);
      check("first_drop_player", bus.current_player, 2'b10);
      for (int i = 0; i < ROWS; i++) do_move(5, 2'b00, 1'b0);
      do_move(5, 2'b00, 1'b0);
      do_move(COLS, 2'b00, 1'b0);
      repeat (15) do_move($urandom_range(0, 7), 2'b00, 1'b0);
      do_move(pick_open_col(), 2'b10, 1'b0);
      check("win_winner", bus.winner, 2'b10);

      repeat (4) begin
         bus.move_valid = 1'b1;
         bus.move_col   = 3'($urandom_range(0, COLS - 1));
         @(negedge clk);
         check("over_no_reject", bus.move_reject, 0);
         check("over_no_write", bus.wr_en, 0);
         tick();
      end
      bus.move_valid = 1'b0;

      new_game_now();
      guard = 0;
      while (m_pieces < CELLS && guard < 2000) begin
         do_move($urandom_range(0, 7), 2'b00, 1'b0);
         guard++;
      end
      check("draw_winner", bus.winner, 2'b11);
      check("draw_over", bus.game_over, 1);

      new_game_now();
      do_move(pick_open_col(), 2'b00, 1'b1);
      check("abort_winner", bus.winner, 2'b00);
      check("abort_player", bus.current_player, 2'b01);
      check_display();

      repeat (5) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
